// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32 front-end definitions: data width, the canonical
//               NOP encoding (addi x0,x0,0) and the fetch FSM state type.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    STALL  = 2'd2,
    SQUASH = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_id_register.sv
`default_nettype none
// ============================================================================
// Module      : if_id_register
// Description : IF/ID pipeline register with bubble / load / hold control.
//               bubble has priority over load; with neither, contents hold.
// Ports       : clk, rst_n       - clock, async active-low reset
//               load, bubble     - capture fetch data / insert NOP bubble
//               instr_in, pc_in, pc_plus4_in - fetch-side data
//               instr_id, pc_id, pc_plus4_id, valid_id - registered outputs
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_register
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            bubble,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  output logic [XLEN-1:0] instr_id,
  output logic [XLEN-1:0] pc_id,
  output logic [XLEN-1:0] pc_plus4_id,
  output logic            valid_id
);

  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic            r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr    <= NOP_INSTR;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (bubble) begin
      r_instr    <= NOP_INSTR;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (load) begin
      r_instr    <= instr_in;
      r_pc       <= pc_in;
      r_pc_plus4 <= pc_plus4_in;
      r_valid    <= 1'b1;
    end
  end

  assign instr_id    = r_instr;
  assign pc_id       = r_pc;
  assign pc_plus4_id = r_pc_plus4;
  assign valid_id    = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage: PC register, next-PC selection,
//               IF/ID register, fetch FSM and stall/squash perf counters.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               pc_write_id                - 0 = load-use stall
//               flush, flush_pc            - squash IF/ID
//               flush_adder                - freeze PC increment
//               branch_taken_mem, branch_target_mem - MEM-stage redirect
//               imem_rdata / imem_addr     - combinational instruction memory
//               instr_id, pc_id, pc_plus4_id, valid_id - IF/ID contents
//               fetch_state                - FSM state (debug)
//               stall_count, squash_count  - saturating perf counters
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write_id,
  input  logic        flush,
  input  logic        flush_pc,
  input  logic        flush_adder,
  input  logic        branch_taken_mem,
  input  logic [31:0] branch_target_mem,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] instr_id,
  output logic [31:0] pc_id,
  output logic [31:0] pc_plus4_id,
  output logic        valid_id,
  output logic [1:0]  fetch_state,
  output logic [15:0] stall_count,
  output logic [15:0] squash_count
);

  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  fetch_state_t    r_state;
  fetch_state_t    w_next_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_boot;
  logic            w_squash;
  logic            w_stall;
  logic            w_ifid_load;
  logic            w_ifid_bubble;
  logic [15:0]     r_stall_count;
  logic [15:0]     r_squash_count;

  assign w_boot     = (r_state == BOOT);
  assign w_squash   = branch_taken_mem | flush | flush_pc;
  assign w_stall    = ~pc_write_id;
  assign w_pc_plus4 = r_pc + 32'd4;   // wraps naturally at 2^32

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BOOT;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = RUN;
    case (r_state)
      BOOT:    w_next_state = RUN;
      default: begin
        if (w_squash)     w_next_state = SQUASH;
        else if (w_stall) w_next_state = STALL;
        else              w_next_state = RUN;
      end
    endcase
  end

  // ---------------- PC ----------------
  // Redirect beats stall; flush_adder only freezes the increment.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (w_boot)                         w_pc_next = RESET_PC;
    else if (branch_taken_mem)          w_pc_next = branch_target_mem;
    else if (w_stall || flush_adder)    w_pc_next = r_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pc <= RESET_PC;
    else        r_pc <= w_pc_next;
  end

  assign imem_addr = r_pc;

  // ---------------- IF/ID ----------------
  assign w_ifid_bubble = w_boot | w_squash;
  assign w_ifid_load   = ~w_boot & ~w_squash & ~w_stall;

  if_id_register u_if_id (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (w_ifid_load),
    .bubble      (w_ifid_bubble),
    .instr_in    (imem_rdata),
    .pc_in       (r_pc),
    .pc_plus4_in (w_pc_plus4),
    .instr_id    (instr_id),
    .pc_id       (pc_id),
    .pc_plus4_id (pc_plus4_id),
    .valid_id    (valid_id)
  );

  // ---------------- counters ----------------
  // stall_count ticks on every edge that places the FSM in STALL, so after
  // N stalled cycles the counter reads N while fetch_state shows STALL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count  <= '0;
      r_squash_count <= '0;
    end else if (!w_boot) begin
      if ((w_next_state == STALL) && (r_stall_count != C_CNT_MAX))
        r_stall_count <= r_stall_count + 16'd1;
      if (w_squash && (r_squash_count != C_CNT_MAX))
        r_squash_count <= r_squash_count + 16'd1;
    end
  end

  assign fetch_state  = r_state;
  assign stall_count  = r_stall_count;
  assign squash_count = r_squash_count;

endmodule
`default_nettype wire
